fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of `i_mem`. It owns the program counter and drives the instruction memory's byte address. It pairs each registered `i_mem` read with its PC and hands decode a valid/ready stream of `{instr, pc}`. It absorbs the memory's one-cycle synchronous read latency with a one-entry skid register, so decode stalls and branch redirects never lose or duplicate an instruction.

## Interface
- `ADDR_WIDTH`, 10: byte-address width; must match `i_mem`.
- `WORD_SIZE`, 32: instruction width.
- `RESET_PC`, 0: byte address fetched first after reset; low 2 bits must be 0.

Clock and reset are decided: one clock, and reset is asynchronous and active-high.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  ADDR_WIDTH  byte address to `i_mem.addr`; registered (= `fetch_pc`).
- `imem_instr`  in  WORD_SIZE  from `i_mem.instr`; holds word at the previous cycle's `imem_addr`.
- `redirect_valid`  in  1  branch/jump taken; kill in-flight work and refetch.
- `redirect_pc`  in  ADDR_WIDTH  redirect target; bits [1:0] ignored (forced 0).
- `out_valid`  out  1  instruction available to decode.
- `out_instr`  out  WORD_SIZE  instruction word.
- `out_pc`  out  ADDR_WIDTH  byte address of `out_instr`.
- `out_ready`  in  1  decode accepts; transfer occurs when `out_valid & out_ready`.

## Operation
- State: `fetch_pc`, `resp_valid`, `resp_pc`, `skid_valid`, `skid_instr`, `skid_pc`.
- Issue condition: `issue = !redirect_valid & (out_ready | (!skid_valid & !resp_valid))`.
- On `issue`: `resp_valid <= 1`, `resp_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`. Addition is modulo 2^ADDR_WIDTH, so 0x3FC wraps to 0x000.
- When not issuing: `resp_valid <= 0` and `fetch_pc` holds. `i_mem` still reads, but that data is ignored.
- Output select:
  - If `skid_valid`, output the skid entry.
  - Otherwise, if `resp_valid`, output `imem_instr` with `resp_pc`.
  - `out_valid = (skid_valid | resp_valid) & !redirect_valid`.
- Skid capture: when `resp_valid & !skid_valid & !out_ready & !redirect_valid`, load `imem_instr` and `resp_pc` into the skid and set `skid_valid <= 1`.
- Skid release: clear `skid_valid` when the skid entry transfers.
- The issue rule guarantees `resp_valid` and `skid_valid` are never both 1. A response is never dropped and never overwritten.
- Redirect, which takes priority over everything:
  - `fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}`.
  - `resp_valid <= 0`, `skid_valid <= 0`.
  - No transfer occurs in the redirect cycle, regardless of `out_ready`.

## Timing
- Reset values:
  - `fetch_pc = RESET_PC`, so `imem_addr = RESET_PC`.
  - `resp_valid = 0`, `skid_valid = 0`, `skid_instr = 0`, `skid_pc = 0`.
  - Therefore `out_valid = 0` and `out_pc = 0` while `rst` is high.
- Reset assertion mid-operation clears state immediately and asynchronously. Any in-flight read is discarded.
- Startup: in the first edge after reset deasserts, `RESET_PC` issues. One cycle later, `out_valid = 1` with `out_pc = RESET_PC`.
- Throughput with `out_ready` held high: one instruction per cycle, no bubbles.
- Stall entry: the displayed instruction moves into the skid on the next edge and remains stable on `out_*`. No new issue occurs while stalled.
- Stall release: the skid entry transfers, the next PC issues in the same cycle, and the next instruction appears on the following cycle with no bubble.
- Redirect latency: redirect at cycle t, target issued at t+1, `out_valid` with `out_pc = target` at t+2. `out_valid` is 0 at t and at t+1.
- `out_*` are combinational from registers and `imem_instr` only. There is no combinational path from `out_ready` to `out_instr` or `out_pc`.

## Test plan
- Reset release, `out_ready = 1`, `rom[i] = 0xA000_0000 + i` → `out_pc` = 0x000, 0x004, 0x008… on consecutive cycles starting one cycle after release, with `out_instr` matching. `out_valid` never drops.
- `out_ready = 0` for 3 cycles while `out_pc = 0x008` → `out_pc` and `out_instr` hold 0x008/`rom[2]` throughout. After release, the accepted sequence is exactly 0x008, 0x00C, 0x010 with no gap and no duplicate.
- Redirect to 0x040 while the skid is full and `out_ready = 0` → `out_valid = 0` at t and t+1. At t+2, `out_pc = 0x040`; the old 0x008 is never accepted.
- `redirect_pc = 0x043` → `imem_addr = 0x040` next cycle, and the first output has `out_pc = 0x040`.
- `RESET_PC = 0x3FC`, `out_ready = 1` → `out_pc` = 0x3FC, then 0x000, then 0x004.
- `rst` pulsed during a stall with the skid full → `out_valid` falls without waiting for a clock edge. The fetch sequence restarts at `RESET_PC` one cycle after release.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory address/data, redirect request, decode stream.
// Latency: none (wires only).
// Backpressure: out_valid/out_ready handshake toward decode; i_mem has none.
//
// Signals:
//   imem_addr      fetch -> i_mem   byte address (registered in the fetch unit)
//   imem_instr     i_mem -> fetch   word at the previous cycle's imem_addr
//   redirect_valid ctrl  -> fetch   taken branch/jump, kill in-flight work
//   redirect_pc    ctrl  -> fetch   redirect target, bits [1:0] ignored
//   out_valid      fetch -> decode  instruction available
//   out_instr      fetch -> decode  instruction word
//   out_pc         fetch -> decode  byte address of out_instr
//   out_ready      decode -> fetch  decode accepts this cycle
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_SIZE  = 32
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [WORD_SIZE-1:0]  imem_instr;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic [WORD_SIZE-1:0]  out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  out_ready;

  // Fetch-unit side.
  modport master (
    output imem_addr, out_valid, out_instr, out_pc,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  // Environment side (memory, branch unit, decode).
  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, pairs each synchronous i_mem read with its PC.
// Latency: instruction appears one cycle after its address issues; redirect-to-output is 2 cycles.
// Backpressure: out_ready low parks the in-flight word in a 1-entry skid and stops issuing.
//
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset
//   bus  fetch_unit_if.master: imem_addr/imem_instr, redirect_valid/redirect_pc,
//        out_valid/out_instr/out_pc/out_ready
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    WORD_SIZE  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [WORD_SIZE-1:0]  skid_instr_q, skid_instr_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;

  logic                  issue;
  logic [ADDR_WIDTH-1:0] redirect_tgt;

  // Target is forced word-aligned; the low two bits are deliberately dropped.
  logic                  unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    // Only issue when the word coming back next cycle is guaranteed a home:
    // either decode is draining this cycle, or both holding slots are empty.
    issue        = !bus.redirect_valid & (bus.out_ready | (!skid_valid_q & !resp_valid_q));
    redirect_tgt = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    fetch_pc_d   = fetch_pc_q;
    resp_valid_d = 1'b0;
    resp_pc_d    = resp_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (bus.redirect_valid) begin
      // Drop the in-flight read and any parked word; refetch from the target.
      fetch_pc_d   = redirect_tgt;
      skid_valid_d = 1'b0;
    end else begin
      if (issue) begin
        resp_valid_d = 1'b1;
        resp_pc_d    = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + ADDR_WIDTH'(4);
      end
      // i_mem data is only valid for one cycle, so a stalled response must be
      // captured now. issue is low in that case, so nothing is overwritten.
      if (resp_valid_q & !skid_valid_q & !bus.out_ready) begin
        skid_valid_d = 1'b1;
        skid_instr_d = bus.imem_instr;
        skid_pc_d    = resp_pc_q;
      end else if (skid_valid_q & bus.out_ready) begin
        skid_valid_d = 1'b0;
      end
    end
  end

  // Outputs depend on registers and imem_instr only; out_ready never steers data.
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = (skid_valid_q | resp_valid_q) & !bus.redirect_valid;
  assign bus.out_instr = skid_valid_q ? skid_instr_q : bus.imem_instr;
  assign bus.out_pc    = skid_valid_q ? skid_pc_q    : resp_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(10), .WORD_SIZE(32)) bus1 ();
  fetch_unit_if #(.ADDR_WIDTH(10), .WORD_SIZE(32)) bus2 ();

  fetch_unit #(.ADDR_WIDTH(10), .WORD_SIZE(32), .RESET_PC(10'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  fetch_unit #(.ADDR_WIDTH(10), .WORD_SIZE(32), .RESET_PC(10'h3FC)) dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Instruction ROM with one-cycle synchronous read, one port per DUT.
  logic [31:0] rom [256];
  always @(posedge clk) bus1.imem_instr <= rom[bus1.imem_addr[9:2]];
  always @(posedge clk) bus2.imem_instr <= rom[bus2.imem_addr[9:2]];

  int checks = 0;
  int errors = 0;

  // Reference model: each DUT must deliver a sequential word stream starting
  // at its restart PC; after a restart (reset release or redirect) output is
  // absent for exactly one more cycle, and never during a redirect cycle.
  int          wait1, wait2;
  logic [9:0]  exp1, exp2;
  logic        addr_due;
  logic [9:0]  addr_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid",    32'(bus1.out_valid), 32'd0);
    chk("rst_pc",       32'(bus1.out_pc),    32'd0);
    chk("rst_addr",     32'(bus1.imem_addr), 32'h000);
    chk("rst_valid_hi", 32'(bus2.out_valid), 32'd0);
    chk("rst_addr_hi",  32'(bus2.imem_addr), 32'h3FC);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_hold_addr",  32'(bus2.imem_addr), 32'h3FC);
    rst      = 1'b0;
    wait1    = 1;
    wait2    = 1;
    exp1     = 10'h000;
    exp2     = 10'h3FC;
    addr_due = 1'b0;
  endtask

  // Called at posedge+1: drive, check at mid-cycle, advance model across the edge.
  task automatic cycle(input bit rdy, input bit redir, input logic [9:0] tgt);
    bit ev1, ev2;
    bus1.out_ready      = rdy;
    bus1.redirect_valid = redir;
    bus1.redirect_pc    = tgt;
    #4;
    ev1 = (wait1 == 0) && !redir;
    chk("valid", 32'(bus1.out_valid), 32'(ev1));
    if (ev1) begin
      chk("pc",    32'(bus1.out_pc), 32'(exp1));
      chk("instr", bus1.out_instr,   rom[exp1[9:2]]);
    end
    if (addr_due) chk("redir_addr", 32'(bus1.imem_addr), 32'(addr_exp));
    ev2 = (wait2 == 0);
    chk("valid_hi", 32'(bus2.out_valid), 32'(ev2));
    if (ev2) begin
      chk("pc_hi",    32'(bus2.out_pc), 32'(exp2));
      chk("instr_hi", bus2.out_instr,   rom[exp2[9:2]]);
    end
    @(posedge clk);
    addr_due = 1'b0;
    if (redir) begin
      exp1     = {tgt[9:2], 2'b00};
      wait1    = 1;
      addr_due = 1'b1;
      addr_exp = {tgt[9:2], 2'b00};
    end else if (wait1 > 0) begin
      wait1--;
    end else if (rdy) begin
      exp1 = exp1 + 10'd4;
    end
    if (wait2 > 0) wait2--;
    else           exp2 = exp2 + 10'd4;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 + 32'(i);
    bus1.out_ready      = 1'b1;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc    = '0;
    bus2.out_ready      = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;
    wait1 = 0; wait2 = 0; exp1 = '0; exp2 = '0;
    addr_due = 1'b0; addr_exp = '0;

    #2;
    do_reset();

    // Startup and full-rate streaming up to pc 0x008 on display.
    repeat (3) cycle(1'b1, 1'b0, 10'h0);
    chk("stream_at_8", 32'(exp1), 32'h008);
    // Three-cycle stall holding 0x008, then release.
    repeat (3) cycle(1'b0, 1'b0, 10'h0);
    repeat (4) cycle(1'b1, 1'b0, 10'h0);

    // Stall to fill the skid, then redirect to 0x040 while still stalled.
    repeat (2) cycle(1'b0, 1'b0, 10'h0);
    cycle(1'b0, 1'b1, 10'h040);
    repeat (4) cycle(1'b1, 1'b0, 10'h0);

    // Unaligned redirect target.
    cycle(1'b1, 1'b1, 10'h043);
    repeat (4) cycle(1'b1, 1'b0, 10'h0);

    // Randomized readiness and redirects.
    for (int n = 0; n < 400; n++) begin
      bit         r, d;
      logic [9:0] t;
      r = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 15) == 0);
      t = 10'($urandom_range(0, 1023));
      cycle(r, d, t);
    end

    // Async reset during a stall with the skid full, then restart.
    repeat (2) cycle(1'b1, 1'b0, 10'h0);
    repeat (2) cycle(1'b0, 1'b0, 10'h0);
    do_reset();
    repeat (6) cycle(1'b1, 1'b0, 10'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
